// File: rtl/led_row_scan_if.sv
// Panel-side signal bundle for the row-scan sequencer.
// The sequencer owns every output and only listens to the enable request.
interface led_row_scan_if #(
    parameter int ROW_BITS = 4,
    parameter int COLS     = 64,
    parameter int PLANES   = 3
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PL_W  = (PLANES > 1) ? $clog2(PLANES) : 1;

    logic                enable;
    logic [ROW_BITS-1:0] row_addr;
    logic                oe_n;
    logic                lat;
    logic                shift_en;
    logic [COL_W-1:0]    col;
    logic [ROW_BITS-1:0] shift_row;
    logic [PL_W-1:0]     plane;
    logic                frame_start;

    // Requesting side: raises enable, observes the scan sequence.
    modport master (
        output enable,
        input  row_addr, oe_n, lat, shift_en, col, shift_row, plane, frame_start
    );

    // Sequencer side: drives the panel timing signals.
    modport slave (
        input  enable,
        output row_addr, oe_n, lat, shift_en, col, shift_row, plane, frame_start
    );
endinterface

// File: rtl/led_row_scan.sv
// HUB75-style row-scan sequencer: for each row and bit plane it shifts COLS
// pixels, blanks the panel, latches the row, then displays it for a
// binary-weighted dwell (BASE_TICKS << plane). All outputs are registered.
module led_row_scan #(
    parameter int ROW_BITS     = 4,
    parameter int COLS         = 64,
    parameter int PLANES       = 3,
    parameter int BLANK_CYCLES = 2,
    parameter int BASE_TICKS   = 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    led_row_scan_if.slave bus
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PL_W  = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    // Longest dwell is computed in 64 bits so the timer width never truncates it;
    // the +1 keeps BASE_TICKS itself representable even when PLANES == 1.
    localparam logic [63:0] MAX_DWELL = 64'(BASE_TICKS) << (PLANES - 1);
    localparam int          TMR_W     = $clog2(MAX_DWELL + 64'd1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);
    localparam logic [PL_W-1:0]  PL_LAST  = PL_W'(PLANES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_BLANK = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_SHOW  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [BLK_W-1:0]    blank_q, blank_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [ROW_BITS-1:0] shift_row_q, shift_row_d;
    logic [PL_W-1:0]     plane_q, plane_d;
    logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
    logic                oe_n_q, oe_n_d;
    logic                lat_q, lat_d;
    logic                shift_en_q, shift_en_d;
    logic                frame_start_q, frame_start_d;

    // Next-state decode: strobes default to inactive and the panel to dark,
    // so only the states that need them turn anything on.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        blank_d       = blank_q;
        tmr_d         = tmr_q;
        shift_row_d   = shift_row_q;
        plane_d       = plane_q;
        row_addr_d    = row_addr_q;
        oe_n_d        = 1'b1;
        lat_d         = 1'b0;
        shift_en_d    = 1'b0;
        frame_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d       = S_SHIFT;
                    shift_en_d    = 1'b1;
                    col_d         = '0;
                    shift_row_d   = '0;
                    plane_d       = '0;
                    frame_start_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (col_q == COL_LAST) begin
                    state_d = S_BLANK;
                    blank_d = '0;
                end else begin
                    shift_en_d = 1'b1;
                    col_d      = col_q + COL_W'(1);
                end
            end
            S_BLANK: begin
                if (blank_q == BLK_LAST) begin
                    // The row address moves together with the latch strobe.
                    state_d    = S_LATCH;
                    lat_d      = 1'b1;
                    row_addr_d = shift_row_q;
                end else begin
                    blank_d = blank_q + BLK_W'(1);
                end
            end
            S_LATCH: begin
                state_d = S_SHOW;
                oe_n_d  = 1'b0;
                tmr_d   = (TMR_W'(BASE_TICKS) << plane_q) - TMR_W'(1);
            end
            S_SHOW: begin
                if (tmr_q != '0) begin
                    oe_n_d = 1'b0;
                    tmr_d  = tmr_q - TMR_W'(1);
                end else if (!bus.enable) begin
                    // Stop cleanly between planes; the panel keeps its last row address.
                    state_d     = S_IDLE;
                    col_d       = '0;
                    shift_row_d = '0;
                    plane_d     = '0;
                end else begin
                    state_d    = S_SHIFT;
                    shift_en_d = 1'b1;
                    col_d      = '0;
                    if (plane_q != PL_LAST) begin
                        plane_d = plane_q + PL_W'(1);
                    end else begin
                        plane_d       = '0;
                        shift_row_d   = shift_row_q + ROW_BITS'(1);
                        frame_start_d = (shift_row_q == '1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset darkens the panel without waiting for a clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            blank_q       <= '0;
            tmr_q         <= '0;
            shift_row_q   <= '0;
            plane_q       <= '0;
            row_addr_q    <= '0;
            oe_n_q        <= 1'b1;
            lat_q         <= 1'b0;
            shift_en_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            blank_q       <= blank_d;
            tmr_q         <= tmr_d;
            shift_row_q   <= shift_row_d;
            plane_q       <= plane_d;
            row_addr_q    <= row_addr_d;
            oe_n_q        <= oe_n_d;
            lat_q         <= lat_d;
            shift_en_q    <= shift_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.row_addr    = row_addr_q;
    assign bus.oe_n        = oe_n_q;
    assign bus.lat         = lat_q;
    assign bus.shift_en    = shift_en_q;
    assign bus.col         = col_q;
    assign bus.shift_row   = shift_row_q;
    assign bus.plane       = plane_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_led_row_scan.sv
// Bench for led_row_scan: a small configuration checked cycle by cycle against
// a schedule-building reference model, plus a default-parameter instance
// checked for frame period and latch count.
module tb_led_row_scan;
    localparam int S_ROWB   = 2;
    localparam int S_COLS   = 4;
    localparam int S_PLANES = 2;
    localparam int S_BLANK  = 1;
    localparam int S_BASE   = 2;
    localparam int S_FRAME  = 72;
    localparam int D_FRAME  = 3328;
    localparam int D_LATS   = 48;
    localparam int NV       = 23;

    typedef struct {
        logic       rst;
        logic       en;
        logic       oe_n;
        logic       lat;
        logic       sh;
        logic       fs;
        logic       chk_col;
        logic [1:0] col;
        logic [1:0] srow;
        logic [0:0] plane;
        logic [1:0] addr;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_row_scan_if #(.ROW_BITS(S_ROWB), .COLS(S_COLS), .PLANES(S_PLANES)) sbus ();
    led_row_scan_if dbus ();

    led_row_scan #(
        .ROW_BITS(S_ROWB), .COLS(S_COLS), .PLANES(S_PLANES),
        .BLANK_CYCLES(S_BLANK), .BASE_TICKS(S_BASE)
    ) u_small (
        .clk_in(clk), .rst_in(rst), .bus(sbus.slave)
    );

    led_row_scan u_dflt (
        .clk_in(clk), .rst_in(rst), .bus(dbus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: a queue holding the remaining cycles of the
    // current (row, plane) slot, built from the timing rules directly.
    rec_t seg_q[$];
    rec_t exp_rec;
    rec_t tbl[NV];
    int   m_row   = 0;
    int   m_plane = 0;
    int   m_addr  = 0;

    int last_fs, lat_idx, sh_run, oe_run, oe_idx, found, dwell_seen, drop_plane;
    int fs_seen, lats;

    function automatic rec_t mk(input logic rst_v, input logic en_v, input logic oe,
                                input logic lt, input logic sh, input logic fs,
                                input logic chk, input int c, input int r,
                                input int p, input int a);
        rec_t x;
        x.rst = rst_v; x.en = en_v; x.oe_n = oe; x.lat = lt; x.sh = sh; x.fs = fs;
        x.chk_col = chk; x.col = 2'(c); x.srow = 2'(r); x.plane = 1'(p); x.addr = 2'(a);
        return x;
    endfunction

    task automatic model_step();
        if (rst) begin
            seg_q.delete();
            m_row = 0; m_plane = 0; m_addr = 0;
            exp_rec = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        end else begin
            if (seg_q.size() == 0) begin
                if (!sbus.enable) begin
                    m_row = 0; m_plane = 0;
                    seg_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, m_addr));
                end else begin
                    for (int c = 0; c < S_COLS; c++)
                        seg_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                           (c == 0 && m_row == 0 && m_plane == 0), 1'b1,
                                           c, m_row, m_plane, m_addr));
                    for (int b = 0; b < S_BLANK; b++)
                        seg_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                           0, m_row, m_plane, m_addr));
                    seg_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                       0, m_row, m_plane, m_row));
                    for (int d = 0; d < (S_BASE << m_plane); d++)
                        seg_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           0, m_row, m_plane, m_row));
                    m_addr = m_row;
                    m_plane++;
                    if (m_plane == S_PLANES) begin
                        m_plane = 0;
                        m_row = (m_row + 1) % (1 << S_ROWB);
                    end
                end
            end
            exp_rec = seg_q.pop_front();
        end
    endtask

    task automatic check(input string name, input rec_t e);
        logic [10:0] act;
        logic [10:0] req;
        act = {sbus.oe_n, sbus.lat, sbus.shift_en, sbus.frame_start, sbus.row_addr,
               sbus.shift_row, sbus.plane, (e.chk_col ? sbus.col : 2'b00)};
        req = {e.oe_n, e.lat, e.sh, e.fs, e.addr, e.srow, e.plane,
               (e.chk_col ? e.col : 2'b00)};
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got oe,lat,sh,fs,addr,row,pl,col=%b required %b",
                     name, cyc, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0d required %0d", name, cyc, got, want);
        end
    endtask

    // One clock: step the model on the active edge, sample on the falling edge.
    task automatic tick(input bit do_chk, input string name);
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        if (do_chk) check(name, exp_rec);
    endtask

    initial begin
        sbus.enable = 1'b0;
        dbus.enable = 1'b0;

        // Reset, start, plane 0 -> plane 1, enable dropped mid-shift, idle, restart.
        tbl[0]  = mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 1, 0, 1, 2, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1, 0, 1, 0, 1, 3, 0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 1, 0, 1, 0, 1, 0, 0, 1, 0);
        tbl[11] = mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0);
        tbl[12] = mk(0, 0, 1, 0, 1, 0, 1, 2, 0, 1, 0);
        tbl[13] = mk(0, 0, 1, 0, 1, 0, 1, 3, 0, 1, 0);
        tbl[14] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[15] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[20] = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[22] = mk(0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst;
            sbus.enable = tbl[i].en;
            tick(1'b0, "");
            check($sformatf("vec%0d", i), tbl[i]);
            $display("[TB] vec %0d rst=%0d en=%0d oe_n=%0d lat=%0d sh=%0d col=%0d row=%0d plane=%0d addr=%0d fs=%0d",
                     i, rst, sbus.enable, sbus.oe_n, sbus.lat, sbus.shift_en, sbus.col,
                     sbus.shift_row, sbus.plane, sbus.row_addr, sbus.frame_start);
        end

        // Enable held for three frames; the last vector showed column 0 of row 0 plane 0.
        last_fs = cyc; sh_run = 1; lat_idx = 0; oe_run = 0; oe_idx = 0;
        for (int i = 0; i < 3 * S_FRAME; i++) begin
            tick(1'b1, "hold");
            if (sbus.frame_start) begin
                chk_int("fs_period", cyc - last_fs, S_FRAME);
                chk_int("wrap_pos", int'({sbus.shift_row, sbus.plane, sbus.col}), 0);
                last_fs = cyc;
            end
            if (sbus.shift_en) sh_run = (int'(sbus.col) == sh_run) ? sh_run + 1 : 100;
            if (sbus.lat) begin
                chk_int("lat_row", int'(sbus.row_addr), (lat_idx / 2) % 4);
                chk_int("lat_shifts", sh_run, S_COLS);
                sh_run = 0;
                lat_idx++;
            end
            if (sbus.lat || sbus.shift_en) chk_int("oe_guard", int'(sbus.oe_n), 1);
            if (!sbus.oe_n) oe_run++;
            else if (oe_run > 0) begin
                chk_int("dwell", oe_run, S_BASE << (oe_idx % 2));
                oe_idx++;
                oe_run = 0;
            end
        end
        $display("[TB] hold run done: %0d frames, %0d latches", 3, lat_idx);

        // Drop enable during a row 1 shift: that plane finishes, then idle.
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick(1'b1, "seek_row1");
            if (sbus.shift_en && sbus.shift_row == 2'd1) found = 1;
        end
        chk_int("seek_row1_found", found, 1);
        drop_plane = int'(sbus.plane);
        sbus.enable = 1'b0;
        oe_run = 0; dwell_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, "drop");
            if (!sbus.oe_n) oe_run++;
            else if (oe_run > 0 && dwell_seen == 0) dwell_seen = oe_run;
        end
        chk_int("drop_dwell", dwell_seen, S_BASE << drop_plane);
        chk_int("idle_addr", int'(sbus.row_addr), 1);
        chk_int("idle_oe_n", int'(sbus.oe_n), 1);
        chk_int("idle_sh", int'(sbus.shift_en), 0);
        sbus.enable = 1'b1;
        tick(1'b1, "restart");
        chk_int("restart_fs", int'(sbus.frame_start), 1);
        chk_int("restart_row", int'(sbus.shift_row), 0);
        $display("[TB] enable drop/restart sequence done");

        // Asynchronous reset in the middle of a SHOW dwell.
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick(1'b1, "seek_show");
            if (!sbus.oe_n) found = 1;
        end
        chk_int("seek_show_found", found, 1);
        @(posedge clk);
        model_step();
        cyc++;
        #2 rst = 1'b1;
        #1 check("async_rst", mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        chk_int("d_async_oe_n", int'(dbus.oe_n), 1);
        tick(1'b1, "rst_hold");
        tick(1'b1, "rst_hold");
        rst = 1'b0;
        tick(1'b1, "rst_release");
        chk_int("release_start", int'({sbus.frame_start, sbus.shift_en, sbus.shift_row, sbus.plane}),
                int'(5'b11000));
        $display("[TB] async reset sequence done");

        // Randomised enable toggling and occasional resets against the model.
        for (int i = 0; i < 1500; i++) begin
            tick(1'b1, "rand");
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 24) == 0) sbus.enable = ~sbus.enable;
        end
        rst = 1'b0;
        $display("[TB] random run done");

        // Default parameters: frame period and latches per frame.
        rst = 1'b1;
        tick(1'b1, "d_rst");
        chk_int("d_rst_oe_n", int'(dbus.oe_n), 1);
        rst = 1'b0;
        dbus.enable = 1'b1;
        fs_seen = 0; last_fs = -1; lats = 0;
        for (int i = 0; i < 3 * D_FRAME + 20 && fs_seen < 3; i++) begin
            tick(1'b1, "d_run");
            if (dbus.lat) lats++;
            if (dbus.frame_start) begin
                if (last_fs >= 0) begin
                    chk_int("d_period", cyc - last_fs, D_FRAME);
                    chk_int("d_lats", lats, D_LATS);
                end
                last_fs = cyc;
                lats = 0;
                fs_seen++;
            end
        end
        chk_int("d_frames", fs_seen, 3);
        $display("[TB] default-parameter frames done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
